uart_receiver: RTL
==================

# uart_receiver

Oversampling UART receiver: the receive-side counterpart of the existing `uart_transmitter` on the badge ECP5. It consumes the same one-clock-wide 16x `sample_tick` that the transmitter uses from `baud_rate_generator`. It deserialises 8N1-style frames from the `interconnect` RX pin and presents each received byte with a one-cycle done strobe and error flags. The block sits beside `UART_TX_UNIT` in `top` and feeds `rx_out` to the LEDs.

## Interface
- `DBITS`, 8, data bits per frame, LSB first.
- `SB_TICK`, 16, sample ticks per stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `clk_100MHz` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high; also clears the synchroniser.
- `rx` input 1: asynchronous serial line; idle high.
- `sample_tick` input 1: 16x baud enable, one `clk_100MHz` cycle wide.
- `data_out` output DBITS: last received word.
- `rx_done` output 1: one-cycle pulse at frame completion.
- `frame_err` output 1: stop bit sampled low on last frame.
- `parity_err` output 1: parity mismatch on last frame (0 when parity compiled out).
- `state_out` output 3: FSM state, for LED debug.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All FSM decisions use the synchronised value `rx_s`.
- Counters:
  - `s_cnt` is 4 bits and counts `sample_tick`s; it is 5 bits if `SB_TICK` > 16.
  - `n_cnt` counts bits, width clog2(DBITS).
- All counters advance only on cycles where `sample_tick` = 1.
- FSM states and `state_out` encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- IDLE: when `rx_s` = 0, go to START with `s_cnt` = 0. No tick is required for this transition.
- START:
  - On the tick where `s_cnt` = 7 (mid start bit), sample `rx_s`.
  - If 0: clear `s_cnt` and `n_cnt`, go to DATA.
  - If 1: false start, return to IDLE, no strobe.
- DATA:
  - On the tick where `s_cnt` = 15, shift `rx_s` into the MSB of the shift register (right shift) and clear `s_cnt`.
  - If `n_cnt` = DBITS-1, go to PARITY (macro on) or STOP (macro off); otherwise increment `n_cnt`.
- PARITY: on the tick where `s_cnt` = 15, capture `rx_s` as the parity bit, clear `s_cnt`, go to STOP.
- STOP: on the tick where `s_cnt` = SB_TICK-1, complete the frame and go to IDLE. Frame completion does the following:
  - Load `data_out` from the shift register.
  - Pulse `rx_done`.
  - Set `frame_err` = ~`rx_s`.
  - Set `parity_err` = computed mismatch.
- `data_out`, `frame_err` and `parity_err` hold until the next frame completion. Frames with a framing error still complete and strobe.
- A break (line held low) yields `data_out` = 0 with `frame_err` = 1. The FSM then waits in IDLE; the low line re-enters START and re-checks the start bit each time.

## Timing
- Reset values: state IDLE, `data_out` = 0, `rx_done` = 0, `frame_err` = 0, `parity_err` = 0, counters 0, `state_out` = 0.
- Reset mid-frame aborts the frame immediately with no `rx_done`. The next frame is received normally.
- Pin-to-`rx_s` latency is 2 clocks. IDLE to START takes 1 clock after `rx_s` falls.
- `rx_done` is registered and asserts in the clock after the final stop-bit tick. It is high for exactly one cycle, and `data_out` and the error flags are valid in that same cycle.
- Frame length from the start edge to `rx_done` is 8 + 16·DBITS (+16 with parity) + SB_TICK ticks, ±1 tick of edge-detection jitter.
- `sample_tick` held high continuously is legal: counters then advance once per clock.
- No input handshake: a consumer that misses `rx_done` simply loses the strobe, and `data_out` stays readable.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - A parity bit follows the data bits.
  - Even parity is expected: XOR of data bits plus the parity bit must equal 0, otherwise `parity_err` = 1.
  - The PARITY state is reachable.
- Undefined:
  - PARITY state logic is absent.
  - DATA goes straight to STOP.
  - `parity_err` is tied to constant 0.

## Test plan
- Reset, then `rx` = 1 idle for 1000 clocks -> `rx_done` never asserts, `state_out` = 0, all outputs 0.
- Frame 8'h41 (0x41, 'A'), good stop bit, tick every 4 clocks -> one `rx_done` pulse, `data_out` = 8'h41, `frame_err` = 0.
- Back-to-back frames 8'h55 then 8'hAA with no idle gap -> two `rx_done` pulses with `data_out` 8'h55 then 8'hAA.
- Glitch: `rx` low for 5 ticks only -> returns to IDLE, no `rx_done`. A valid 8'h3C frame afterwards is received correctly.
- Stop bit driven 0 on frame 8'hF0 -> `rx_done` = 1, `data_out` = 8'hF0, `frame_err` = 1. A following good frame clears `frame_err`.
- With `UART_RX_PARITY_EN`:
  - Send 8'h07 with parity bit 1 -> `parity_err` = 0.
  - Then send 8'h07 with parity bit 0 -> `parity_err` = 1.
  - Reset asserted mid-DATA -> no strobe.

Source files
------------

// File: rtl/uart_receiver.sv
// 16x-oversampled 8N1 UART receiver; optional even parity via UART_RX_PARITY_EN.
// Latency: 2-clock synchroniser, rx_done registered one clock after the final stop tick.
// Backpressure: none; rx_done is a one-cycle strobe and data_out/flags hold until the next frame.
module uart_receiver #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  output logic [DBITS-1:0] data_out,
  output logic             rx_done,
  output logic             frame_err,
  output logic             parity_err,
  output logic [2:0]       state_out
);
  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic             rx_m;
  logic             rx_s;
  logic [SW-1:0]    s_cnt;
  logic [NW-1:0]    n_cnt;
  logic [DBITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic             par_bit;
  logic             parity_err_q;
`endif

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state     <= IDLE;
      s_cnt     <= '0;
      n_cnt     <= '0;
      shreg     <= '0;
      data_out  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (sample_tick) begin
            if (s_cnt == S_MID) begin
              if (!rx_s) begin
                s_cnt <= '0;
                n_cnt <= '0;
                state <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              shreg <= {rx_s, shreg[DBITS-1:1]};
              if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n_cnt <= n_cnt + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_tick) begin
            if (s_cnt == S_LAST) begin
              par_bit <= rx_s;
              s_cnt   <= '0;
              state   <= STOP;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (sample_tick) begin
            if (s_cnt == S_STOP) begin
              data_out  <= shreg;
              rx_done   <= 1'b1;
              frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= ^{shreg, par_bit};
`endif
              s_cnt <= '0;
              state <= IDLE;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign state_out = state;

endmodule
